// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (inst, data), the arbiter and a
// single-port synchronous SRAM.
//   i_* / d_* : request (req, wr, wstrb, addr, wdata) and response (addr_ok, data_ok, rdata)
//   sram_*    : en, byte write enables, addr, wdata out; rdata back (1-cycle read latency)
// Modports: slave = arbiter view, master = requesters + SRAM view.
interface mem_arbiter_if;
  logic        i_req;
  logic        i_wr;
  logic [3:0]  i_wstrb;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_wr;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [31:0] d_rdata;

  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  i_req, i_wr, i_wstrb, i_addr, i_wdata,
    output i_addr_ok, i_data_ok, i_rdata,
    input  d_req, d_wr, d_wstrb, d_addr, d_wdata,
    output d_addr_ok, d_data_ok, d_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output i_req, i_wr, i_wstrb, i_addr, i_wdata,
    input  i_addr_ok, i_data_ok, i_rdata,
    output d_req, d_wr, d_wstrb, d_addr, d_wdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (inst/data) arbiter in front of a single-port synchronous SRAM.
// One grant per cycle, combinational from requests and state. Data port has
// priority; inst port is forced to win after STARVE_LIMIT consecutive losses.
// Response (data_ok/rdata) comes exactly one cycle after the grant.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : mem_arbiter_if.slave (requester handshakes and SRAM port)
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_owner_q, resp_owner_d; // 0 = inst, 1 = data
  logic            resp_wr_q, resp_wr_d;

  logic i_gnt, d_gnt, force_i;

  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    force_i = bus.i_req && (starve_cnt_q == Limit);
    if (!reset) begin
      if (bus.d_req && !force_i) begin
        d_gnt = 1'b1;
      end else if (bus.i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    starve_cnt_d = '0;
    if (bus.i_req && !i_gnt) begin
      starve_cnt_d = (starve_cnt_q == Limit) ? Limit : starve_cnt_q + 1'b1;
    end

    resp_valid_d = i_gnt || d_gnt;
    resp_owner_d = resp_owner_q;
    resp_wr_d    = resp_wr_q;
    if (d_gnt) begin
      resp_owner_d = 1'b1;
      resp_wr_d    = bus.d_wr;
    end else if (i_gnt) begin
      resp_owner_d = 1'b0;
      resp_wr_d    = bus.i_wr;
    end
  end

  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_wen   = 4'b0000;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (d_gnt) begin
      bus.sram_en    = 1'b1;
      bus.sram_wen   = bus.d_wr ? bus.d_wstrb : 4'b0000;
      bus.sram_addr  = bus.d_addr;
      bus.sram_wdata = bus.d_wdata;
    end else if (i_gnt) begin
      bus.sram_en    = 1'b1;
      bus.sram_wen   = bus.i_wr ? bus.i_wstrb : 4'b0000;
      bus.sram_addr  = bus.i_addr;
      bus.sram_wdata = bus.i_wdata;
    end
  end

  // Responses are masked during reset so a grant taken just before reset never completes.
  always_comb begin
    bus.i_addr_ok = i_gnt;
    bus.d_addr_ok = d_gnt;
    bus.i_data_ok = !reset && resp_valid_q && !resp_owner_q;
    bus.d_data_ok = !reset && resp_valid_q && resp_owner_q;
    bus.i_rdata   = (bus.i_data_ok && !resp_wr_q) ? bus.sram_rdata : '0;
    bus.d_rdata   = (bus.d_data_ok && !resp_wr_q) ? bus.sram_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
      resp_wr_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
      resp_wr_q    <= resp_wr_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_mem_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    overlap = 0;
  string glog    = "";

  // Model state: consecutive inst losses and the outstanding response.
  int streak   = 0;
  bit pend_v   = 0;
  bit pend_d   = 0;
  bit pend_wr  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_req = 0; bus.i_wr = 0; bus.i_wstrb = 0; bus.i_addr = 0; bus.i_wdata = 0;
    bus.d_req = 0; bus.d_wr = 0; bus.d_wstrb = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.sram_rdata = 0;
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance.
  task automatic tick();
    bit win_i, win_d;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
    logic [3:0]  e_wen;
    bit e_idok, e_ddok;
    #1;
    win_i = 0;
    win_d = 0;
    if (!rst) begin
      if (bus.d_req && !(bus.i_req && streak >= LIMIT)) win_d = 1;
      else if (bus.i_req) win_i = 1;
    end
    e_addr  = win_d ? bus.d_addr  : (win_i ? bus.i_addr  : 32'h0);
    e_wdata = win_d ? bus.d_wdata : (win_i ? bus.i_wdata : 32'h0);
    e_wen   = (win_d && bus.d_wr) ? bus.d_wstrb : ((win_i && bus.i_wr) ? bus.i_wstrb : 4'h0);
    e_idok  = !rst && pend_v && !pend_d;
    e_ddok  = !rst && pend_v && pend_d;
    e_irdata = (e_idok && !pend_wr) ? bus.sram_rdata : 32'h0;
    e_drdata = (e_ddok && !pend_wr) ? bus.sram_rdata : 32'h0;

    check("i_addr_ok",  32'(bus.i_addr_ok), 32'(win_i));
    check("d_addr_ok",  32'(bus.d_addr_ok), 32'(win_d));
    check("sram_en",    32'(bus.sram_en), 32'(win_i | win_d));
    check("sram_wen",   32'(bus.sram_wen), 32'(e_wen));
    check("sram_addr",  bus.sram_addr, e_addr);
    check("sram_wdata", bus.sram_wdata, e_wdata);
    check("i_data_ok",  32'(bus.i_data_ok), 32'(e_idok));
    check("d_data_ok",  32'(bus.d_data_ok), 32'(e_ddok));
    check("i_rdata",    bus.i_rdata, e_irdata);
    check("d_rdata",    bus.d_rdata, e_drdata);

    glog = {glog, bus.d_addr_ok ? "D" : (bus.i_addr_ok ? "I" : "-")};
    if (bus.d_data_ok && bus.i_addr_ok) overlap++;

    @(posedge clk);
    if (rst) begin
      streak = 0;
      pend_v = 0;
      pend_d = 0;
      pend_wr = 0;
    end else begin
      streak = (bus.i_req && !win_i) ? ((streak + 1 > LIMIT) ? LIMIT : streak + 1) : 0;
      pend_v = win_i | win_d;
      if (win_d) begin pend_d = 1; pend_wr = bus.d_wr; end
      else if (win_i) begin pend_d = 0; pend_wr = bus.i_wr; end
    end
    #1;
  endtask

  initial begin
    idle_inputs();
    @(posedge clk); #1;

    // Reset holds everything quiet even with both ports requesting.
    bus.i_req = 1; bus.d_req = 1;
    tick();
    tick();
    idle_inputs();
    rst = 0;
    tick();

    // Single inst read.
    bus.i_req = 1; bus.i_addr = 32'h1C00_0000;
    tick();
    idle_inputs(); bus.sram_rdata = 32'h1234_5678;
    tick();
    idle_inputs();

    // Single data write with partial strobes.
    bus.d_req = 1; bus.d_wr = 1; bus.d_wstrb = 4'b0011;
    bus.d_addr = 32'h100; bus.d_wdata = 32'hAABB_CCDD;
    tick();
    idle_inputs(); bus.sram_rdata = 32'hDEAD_BEEF;
    tick();

    // Sustained contention: starvation forcing pattern.
    glog = "";
    bus.i_req = 1; bus.i_addr = 32'h40; bus.d_req = 1; bus.d_addr = 32'h80;
    for (int k = 0; k < 10; k++) begin
      bus.sram_rdata = $urandom;
      tick();
    end
    check_str("contention_order", glog, "DDDDIDDDDI");
    idle_inputs();
    tick();

    // Alternating data/inst reads, back to back.
    glog = "";
    overlap = 0;
    for (int k = 0; k < 6; k++) begin
      idle_inputs();
      if (k % 2 == 0) begin bus.d_req = 1; bus.d_addr = 32'(k * 4); end
      else begin bus.i_req = 1; bus.i_addr = 32'(k * 8); end
      bus.sram_rdata = $urandom;
      tick();
    end
    idle_inputs(); bus.sram_rdata = $urandom;
    tick();
    check_str("alternate_order", glog, "DIDIDI-");
    check("alternate_overlap", 32'(overlap), 32'd3);

    // Reset right after a data grant drops its response.
    glog = "";
    idle_inputs(); bus.d_req = 1; bus.d_addr = 32'h200;
    tick();
    idle_inputs(); rst = 1; bus.sram_rdata = 32'h5555_AAAA;
    tick();
    rst = 0; bus.i_req = 1; bus.i_addr = 32'h300;
    tick();
    idle_inputs(); bus.sram_rdata = 32'h7777_0000;
    tick();
    check_str("reset_drop", glog, "D-I-");

    // Inst drops out briefly: starvation count restarts.
    glog = "";
    bus.i_req = 1; bus.d_req = 1;
    for (int k = 0; k < 3; k++) tick();
    bus.i_req = 0;
    tick();
    bus.i_req = 1;
    for (int k = 0; k < 5; k++) tick();
    check_str("starve_restart", glog, "DDDDDDDDI");
    idle_inputs();
    tick();

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.i_req   = ($urandom_range(0, 3) != 0);
      bus.i_wr    = $urandom_range(0, 1);
      bus.i_wstrb = 4'($urandom);
      bus.i_addr  = $urandom;
      bus.i_wdata = $urandom;
      bus.d_req   = ($urandom_range(0, 2) != 0);
      bus.d_wr    = $urandom_range(0, 1);
      bus.d_wstrb = 4'($urandom);
      bus.d_addr  = $urandom;
      bus.d_wdata = $urandom;
      bus.sram_rdata = $urandom;
      tick();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive lost-arbitration cycles of the inst port before it is forced to win.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports i_req, i_wr, input, 1 each: inst requester request valid and write flag.
REQ-005 SHALL have ports i_wstrb, input, 4; i_addr, i_wdata, input, 32 each: inst write strobes, address and write data.
REQ-006 SHALL have ports i_addr_ok, i_data_ok, output, 1 each; i_rdata, output, 32: inst accept, response and read data.
REQ-007 SHALL have ports d_req, d_wr, d_wstrb, d_addr, d_wdata, d_addr_ok, d_data_ok and d_rdata, with the widths and meanings of the i_* set, for the data requester.
REQ-008 SHALL have ports sram_en, output, 1; sram_wen, output, 4; sram_addr, sram_wdata, output, 32 each; sram_rdata, input, 32: single-port synchronous SRAM with 1-cycle read latency.

Function
REQ-009 SHALL grant at most one requester per cycle; the grant is combinational from the current requests and state.
REQ-010 SHALL give the data port priority when both request, unless starve_cnt == STARVE_LIMIT, in which case the inst port wins.
REQ-011 SHALL increment starve_cnt, saturating at STARVE_LIMIT, each cycle i_req=1 and the inst port is not granted.
REQ-012 SHALL clear starve_cnt in any cycle the inst port is granted or i_req=0.
REQ-013 SHALL, in a grant cycle, assert the winner's addr_ok=1 and drive sram_en=1, sram_addr=addr and sram_wdata=wdata.
REQ-014 SHALL drive sram_wen=wstrb when wr=1 and 4'b0000 when wr=0 in a grant cycle.
REQ-015 SHALL drive sram_en=0, sram_wen=0, sram_addr=0 and sram_wdata=0 in cycles with no grant.
REQ-016 SHALL hold addr_ok=0 for the losing port and for any port with req=0.
REQ-017 SHALL register resp_valid and resp_owner (0=inst, 1=data) at each grant, and clear resp_valid in cycles with no grant.
REQ-018 SHALL, when resp_valid=1, assert data_ok for resp_owner for exactly one cycle, the cycle after the grant (fixed latency 1).
REQ-019 SHALL drive the owner's rdata=sram_rdata in the data_ok cycle for reads, and 0 for writes.
REQ-020 SHALL hold the non-owner's rdata and all rdata outside data_ok cycles at 0.
REQ-021 SHALL allow a new grant in the same cycle as a data_ok (back-to-back, one grant per cycle sustained) with no bubble.
REQ-022 SHALL treat a requester that holds req=1 after addr_ok as issuing a new request; requesters must keep addr, wr, wstrb and wdata stable until addr_ok.
REQ-023 SHALL allow simultaneous d_data_ok and a new i_addr_ok (and vice versa) in one cycle.

Reset
REQ-024 SHALL, while reset=1, force i_addr_ok, d_addr_ok, i_data_ok, d_data_ok and sram_en to 0, sram_wen to 0, and both rdata to 0.
REQ-025 SHALL, on a clock edge with reset=1, clear resp_valid, resp_owner and starve_cnt to 0.
REQ-026 SHALL drop a grant accepted in the cycle before reset asserts: no data_ok is produced for it after reset.
REQ-027 SHALL allow normal arbitration in the first cycle after reset deasserts.

Verification
REQ-028 SHALL pass this test: i_req=1, read of i_addr=0x1C000000 alone; sram_rdata=0x12345678 next cycle -> i_addr_ok=1 and sram_en=1 in cycle 0; i_data_ok=1 and i_rdata=0x12345678 in cycle 1.
REQ-029 SHALL pass this test: d_req=1, write of d_addr=0x100, d_wstrb=4'b0011, d_wdata=0xAABBCCDD -> sram_wen=4'b0011 and sram_addr=0x100 in cycle 0; d_data_ok=1 and d_rdata=0 in cycle 1.
REQ-030 SHALL pass this test: i_req and d_req both held at 1 continuously with STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I...; exactly one addr_ok per cycle; data_ok for each grant one cycle later.
REQ-031 SHALL pass this test: alternating single-cycle reads on the data then the inst port -> back-to-back grants; d_data_ok and i_addr_ok both 1 in the same cycle; no idle cycles on sram_en.
REQ-032 SHALL pass this test: reset asserted in the cycle after a d_req grant -> d_data_ok stays 0; starve_cnt=0; the first post-reset request is granted in its first cycle.
REQ-033 SHALL pass this test: i_req=1 for 3 cycles against d_req, then i_req=0 for 1 cycle, then contention resumes -> starve_cnt restarts from 0; the inst port is forced only after 4 further losses.
